// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - size encodings carried on req_size
//   - FSM state enum
//   - lane geometry constants and the alignment check helper
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCESS   = 3'd1,
        ST_MERGE_WR = 3'd2,
        ST_RESP     = 3'd3,
        ST_ERR      = 3'd4
    } lsu_state_t;

    // A request is rejected when the size is reserved or the address
    // is not naturally aligned for the access size.
    function automatic logic is_rejected(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   i_word      - 32-bit word read from data memory
//   i_addr_lo   - byte offset within the word (little-endian lanes)
//   i_size      - access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_unsigned  - zero-extend loads when 1, sign-extend when 0
//   i_wdata     - low 16 bits of the store data (upper bits never merged)
//   o_load_data - addressed lane, extended to 32 bits
//   o_merged    - i_word with the addressed lane replaced by store data
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;
    logic              w_byte_fill;
    logic              w_half_fill;

    assign w_byte      = i_word[{i_addr_lo, 3'b000} +: BYTE_W];
    assign w_half      = i_word[{i_addr_lo[1], 4'b0000} +: HALF_W];
    assign w_byte_fill = ~i_unsigned & w_byte[BYTE_W-1];
    assign w_half_fill = ~i_unsigned & w_half[HALF_W-1];

    always_comb begin
        o_load_data = i_word;
        case (i_size)
            SZ_BYTE: o_load_data = {{24{w_byte_fill}}, w_byte};
            SZ_HALF: o_load_data = {{16{w_half_fill}}, w_half};
            default: o_load_data = i_word;
        endcase
    end

    always_comb begin
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: o_merged[{i_addr_lo, 3'b000} +: BYTE_W]    = i_wdata[BYTE_W-1:0];
            SZ_HALF: o_merged[{i_addr_lo[1], 4'b0000} +: HALF_W] = i_wdata;
            default: o_merged = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the CPU memory stage and data_memory.
// Turns byte/half/word requests into word-granular memory accesses:
// loads extract and extend a lane, sub-word stores do read-modify-write,
// misaligned or reserved-size requests are rejected without a memory access.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req_valid/req_ready        - request handshake; transfer when both high
//   req_write/size/unsigned    - request kind
//   req_addr/req_wdata         - byte address, right-justified store data
//   rsp_valid                  - one-cycle completion pulse (no backpressure)
//   rsp_rdata/rsp_misaligned   - load result / rejection flag
//   dmem_write/addr/wdata      - data_memory write port and word address
//   dmem_rdata                 - data_memory combinational read of dmem_addr
//   dbg_state                  - current FSM state (lsu_state_t encoding)
//
// Handshake: req_ready is high only in IDLE; a request transfers on a rising
// edge where req_valid && req_ready, and all request fields are captured on
// that edge. rsp_valid is a single-cycle pulse the CPU must always accept.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_misaligned,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    output logic [2:0]        dbg_state
);

    lsu_state_t        r_state;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_rsp_valid;
    logic              r_rsp_mis;

    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;

    lsu_lane_unit u_lane (
        .i_word      (dmem_rdata),
        .i_addr_lo   (r_addr[1:0]),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_wdata     (r_wdata[15:0]),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_size      <= SZ_BYTE;
            r_unsigned  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_mis   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_mis   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        // Stores and rejected requests report zero data.
                        r_rdata    <= '0;
                        if (is_rejected(req_size, req_addr[1:0])) begin
                            r_state     <= ST_ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_mis   <= 1'b1;
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!r_write) begin
                        r_rdata     <= w_load_data;
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                    end else if (r_size == SZ_WORD) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        // Reuse the store-data register for the merged word so
                        // dmem_wdata always comes straight from one register.
                        r_wdata <= w_merged;
                        r_state <= ST_MERGE_WR;
                    end
                end
                ST_MERGE_WR: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                end
                ST_RESP, ST_ERR: r_state <= ST_IDLE;
                default:         r_state <= ST_IDLE;
            endcase
        end
    end

    // Decoded from state so an asynchronous reset drops it immediately.
    assign dmem_write = (r_state == ST_MERGE_WR) ||
                        ((r_state == ST_ACCESS) && r_write && (r_size == SZ_WORD));

    assign req_ready      = (r_state == ST_IDLE);
    assign dmem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
    assign dmem_wdata     = r_wdata;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_misaligned = r_rsp_mis;
    assign rsp_rdata      = r_rdata;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_misaligned (rsp_misaligned),
    .dmem_write     (dmem_write),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dbg_state      (dbg_state)
  );

  // ---------------- data memory model ----------------
  logic [31:0] mem [0:63];
  logic        tb_we;
  logic [5:0]  tb_waddr;
  logic [31:0] tb_wdata;

  assign dmem_rdata = (dmem_addr[31:8] == 24'h0) ? mem[dmem_addr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    else if (dmem_write) mem[dmem_addr[7:2]] <= dmem_wdata;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [5:0] idx, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_waddr = idx;
    tb_wdata = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Issues one request at the next falling edge and follows it to rsp_valid.
  // lat counts rising edges after the transfer edge (transfer = cycle 0).
  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic rdy_at_issue, output logic [31:0] rd,
                         output logic mis, output int lat, output int wr_cnt,
                         output logic [31:0] wr_data, output int busy_ready);
    @(negedge clk);
    rdy_at_issue = req_ready;
    req_valid = 1'b1;
    req_write = w;
    req_size = sz;
    req_unsigned = u;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    wr_cnt = 0;
    wr_data = 32'h0;
    busy_ready = 0;
    rd = 32'hx;
    mis = 1'bx;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      lat++;
      if (req_ready) busy_ready++;
      if (dmem_write) begin
        wr_cnt++;
        wr_data = dmem_wdata;
      end
      if (rsp_valid) begin
        rd = rsp_rdata;
        mis = rsp_misaligned;
        break;
      end
    end
    if (!rsp_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no rsp_valid within 8 cycles for addr 0x%08h", a);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] pre;
    logic [31:0] exp_rd;
    logic        exp_mis;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[16];

  logic        rdy0;
  logic [31:0] rd;
  logic        mis;
  int          lat;
  int          wr_cnt;
  logic [31:0] wr_data;
  int          busy_ready;
  int          cnt_wr;
  int          cnt_rsp;

  initial begin
    //           w     sz     u     addr      wdata          pre            exp_rd         mis   lat wr exp_mem
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h43, 32'h0,         32'h80FF_7F01, 32'hFFFF_FF80, 1'b0, 2, 0, 32'h80FF_7F01};
    vecs[1]  = '{1'b0, 2'b01, 1'b1, 32'h42, 32'h0,         32'h80FF_7F01, 32'h0000_80FF, 1'b0, 2, 0, 32'h80FF_7F01};
    vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h42, 32'h0,         32'h80FF_7F01, 32'hFFFF_80FF, 1'b0, 2, 0, 32'h80FF_7F01};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h40, 32'h0,         32'h80FF_7F01, 32'h0000_0001, 1'b0, 2, 0, 32'h80FF_7F01};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h41, 32'h0,         32'h80FF_7F01, 32'h0000_007F, 1'b0, 2, 0, 32'h80FF_7F01};
    vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h42, 32'h0,         32'h80FF_7F01, 32'hFFFF_FFFF, 1'b0, 2, 0, 32'h80FF_7F01};
    vecs[6]  = '{1'b0, 2'b10, 1'b1, 32'h40, 32'h0,         32'h80FF_7F01, 32'h80FF_7F01, 1'b0, 2, 0, 32'h80FF_7F01};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h41, 32'h1234_56AB, 32'h1122_3344, 32'h0,         1'b0, 3, 1, 32'h1122_AB44};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h46, 32'hFFFF_BEEF, 32'h1122_3344, 32'h0,         1'b0, 3, 1, 32'hBEEF_3344};
    vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h4B, 32'hFFFF_FFCD, 32'hAABB_CCDD, 32'h0,         1'b0, 3, 1, 32'hCDBB_CCDD};
    vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h4C, 32'hCAFE_F00D, 32'h0,         32'h0,         1'b0, 2, 1, 32'hCAFE_F00D};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h42, 32'h0,         32'h80FF_7F01, 32'h0,         1'b1, 1, 0, 32'h80FF_7F01};
    vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h43, 32'h0000_5555, 32'h80FF_7F01, 32'h0,         1'b1, 1, 0, 32'h80FF_7F01};
    vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h40, 32'h0,         32'h80FF_7F01, 32'h0,         1'b1, 1, 0, 32'h80FF_7F01};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h41, 32'h1111_1111, 32'h80FF_7F01, 32'h0,         1'b1, 1, 0, 32'h80FF_7F01};
    vecs[15] = '{1'b0, 2'b01, 1'b1, 32'h41, 32'h0,         32'h80FF_7F01, 32'h0,         1'b1, 1, 0, 32'h80FF_7F01};

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    tb_we = 1'b0;
    tb_waddr = 6'h0;
    tb_wdata = 32'h0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_misaligned", {31'h0, rsp_misaligned}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_dmem_write", {31'h0, dmem_write}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);

    // ---- table-driven vectors ----
    for (int i = 0; i < 16; i++) begin
      poke(vecs[i].addr[7:2], vecs[i].pre);
      run_req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].addr, vecs[i].wd,
              rdy0, rd, mis, lat, wr_cnt, wr_data, busy_ready);
      @(negedge clk);
      check($sformatf("v%0d_ready_at_issue", i), {31'h0, rdy0}, 32'h1);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_misaligned", i), {31'h0, mis}, {31'h0, vecs[i].exp_mis});
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_write_pulses", i), wr_cnt, vecs[i].exp_wr);
      check($sformatf("v%0d_ready_while_busy", i), busy_ready, 0);
      check($sformatf("v%0d_mem", i), mem[vecs[i].addr[7:2]], vecs[i].exp_mem);
      if (vecs[i].exp_wr != 0)
        check($sformatf("v%0d_dmem_wdata", i), wr_data, vecs[i].exp_mem);
    end

    // ---- back-to-back: word store then load in the first ready cycle ----
    poke(6'h04, 32'h0);
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, rdy0, rd, mis, lat, wr_cnt, wr_data, busy_ready);
    check("b2b_store_latency", lat, 2);
    check("b2b_store_busy_ready", busy_ready, 0);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rdy0, rd, mis, lat, wr_cnt, wr_data, busy_ready);
    check("b2b_load_ready_at_issue", {31'h0, rdy0}, 32'h1);
    check("b2b_load_rdata", rd, 32'hDEAD_BEEF);
    check("b2b_load_latency", lat, 2);
    check("b2b_load_busy_ready", busy_ready, 0);

    // ---- reset during MERGE_WR of a byte store ----
    poke(6'h14, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'h51;
    req_wdata = 32'h0000_0099;
    @(posedge clk);               // transfer
    #1 req_valid = 1'b0;
    @(posedge clk);               // ACCESS -> MERGE_WR
    #2;
    check("rstmid_in_merge_write", {31'h0, dmem_write}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstmid_write_drop", {31'h0, dmem_write}, 32'h0);
    cnt_wr = 0;
    cnt_rsp = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (dmem_write) cnt_wr++;
      if (rsp_valid) cnt_rsp++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dmem_write) cnt_wr++;
      if (rsp_valid) cnt_rsp++;
    end
    check("rstmid_write_pulses", cnt_wr, 0);
    check("rstmid_rsp_pulses", cnt_rsp, 0);
    check("rstmid_mem_unchanged", mem[6'h14], 32'h1122_3344);
    check("rstmid_req_ready", {31'h0, req_ready}, 32'h1);

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU memory stage and data_memory.
- Turns byte, halfword and word load/store requests into word-granular data_memory accesses.
- Loads: extracts the addressed lane and sign- or zero-extends it.
- Sub-word stores: performs read-modify-write. Misaligned accesses are rejected without touching memory.

Parameters:
ADDR_W, 32, width of req_addr and dmem_addr (data path fixed at 32 bits)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  unit accepts request this cycle
req_write  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=reserved
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data (0 for stores and errors)
rsp_misaligned  out  1  request rejected, qualified by rsp_valid
dmem_write  out  1  to data_memory mem_write
dmem_addr  out  ADDR_W  to data_memory address, always {addr[ADDR_W-1:2],2'b00}
dmem_wdata  out  32  to data_memory write_data
dmem_rdata  in  32  from data_memory read_data (combinational read of dmem_addr)

Behaviour:
- Handshake:
  - Transfer occurs when req_valid && req_ready. req_ready=1 only in IDLE.
  - Request fields are latched on transfer.
  - No rsp backpressure: the CPU must accept the rsp_valid pulse.
- States: IDLE, ACCESS, MERGE_WR, RESP, ERR.
- IDLE:
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=11 -> ERR.
  - Any other request -> ACCESS.
- ERR (1 cycle):
  - rsp_valid=1, rsp_misaligned=1, rsp_rdata=0, dmem_write=0.
  - -> IDLE.
- ACCESS:
  - dmem_addr=latched word address.
  - Load: capture lane from dmem_rdata, extend into rsp_rdata register -> RESP.
  - Word store: dmem_write=1, dmem_wdata=latched wdata -> RESP.
  - Sub-word store: dmem_write=0; latch merged word (old dmem_rdata with target lane replaced) -> MERGE_WR.
- MERGE_WR:
  - dmem_write=1, dmem_wdata=merged word -> RESP.
- RESP:
  - rsp_valid=1, rsp_misaligned=0 -> IDLE.
- Lanes are little-endian:
  - byte lane = addr[1:0], bits [8*addr[1:0]+7 : 8*addr[1:0]].
  - half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Extension: signed uses lane MSB; unsigned pads zeros. Word loads ignore req_unsigned.
- Store merge uses only the low 8/16 bits of req_wdata; upper bits are ignored.
- Latency (transfer cycle = 0), rsp_valid asserted in:
  - load: cycle 2
  - word store: cycle 2
  - sub-word store: cycle 3
  - misaligned: cycle 1
- dmem_write is decoded combinationally from state. It is asserted for exactly one cycle per store and never in IDLE, RESP or ERR.
- dmem_addr/dmem_wdata are don't-care when not in ACCESS/MERGE_WR, but must be held stable (latched values) to avoid glitch-driven toggling.
- Reset:
  - rst_n low immediately forces IDLE.
  - rsp_valid=0, rsp_misaligned=0, rsp_rdata=0, dmem_write=0, internal latches cleared.
  - Reset mid-operation aborts the request: no write is issued after rst_n falls, and no response is produced.
- Back-to-back: a new request is accepted in the cycle after RESP/ERR (IDLE). Maximum throughput is one access per 3 cycles (4 for sub-word stores).

Decomposition:
- lsu_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD), state enum, lane-select helper constants.
- Sub-module lsu_lane_unit (combinational):
  - inputs: word, addr[1:0], size, unsigned, store data.
  - outputs: extended load value, merged store word.
  - load_store_unit keeps the FSM, latches and handshake.

Test Plan:
- Memory word 0x40 = 0x80FF_7F01; load byte signed addr 0x43 -> rsp_rdata=0xFFFF_FF80 at cycle 2, dmem_write never asserted.
- Same word; load half unsigned addr 0x42 -> rsp_rdata=0x0000_80FF; load half signed -> 0xFFFF_80FF.
- Store byte 0xAB (req_wdata=0x1234_56AB) to addr 0x41 over word 0x1122_3344 -> one dmem_write pulse in cycle 2 with dmem_wdata=0x1122_AB44, rsp_valid cycle 3.
- Load word addr 0x42, then store half addr 0x43 -> each gives rsp_valid=1, rsp_misaligned=1 at cycle 1, zero dmem_write pulses, memory unchanged.
- Word store 0xDEAD_BEEF to 0x10, load word 0x10 issued the cycle req_ready returns -> load returns 0xDEAD_BEEF; req_ready low during ACCESS/RESP.
- Assert rst_n low during MERGE_WR of a byte store -> dmem_write drops the same cycle, memory word unchanged, no rsp_valid, req_ready=1 after release.
